// File: rtl/seq_feed_ctrl.sv
// seq_feed_ctrl: run controller for a serial sequence detector.
// Loads a test word and clears the detector. Then it shifts the word MSB-first
// into the detector, one bit per clock, and samples the detector output over
// the matching window. When the run ends it reports the hit count and the
// position of the first hit.
// MOORE selects the sampling window. 0: z belongs to the bit presented in the
// same cycle. 1: z lags the bit by one cycle.
module seq_feed_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5,
  parameter int MOORE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNTW-1:0]  len,
  input  logic [WIDTH-1:0] pattern,
  input  logic             z,
  output logic             x,
  output logic             det_clear,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  hit_count,
  output logic [CNTW-1:0]  first_hit
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNTW-1:0] ONES    = '1;
  localparam logic [CNTW-1:0] WIDTH_C = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] sr_r;
  logic [CNTW-1:0]  len_r;
  logic [CNTW-1:0]  idx_r;

  logic [CNTW-1:0]  len_clamp_s;
  logic             last_s;
  logic             sample_en_s;
  logic [CNTW-1:0]  sample_pos_s;

  // Saturating increment: the hit counter sticks at all-ones.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == ONES) ? v : v + ONE_C;
  endfunction

  // Clamp the requested length to the shift register size.
  always_comb begin
    len_clamp_s = len;
    if (len > WIDTH_C) begin
      len_clamp_s = WIDTH_C;
    end else begin
      len_clamp_s = len;
    end
  end

  // The current SHIFT cycle presents the final bit of the word.
  always_comb begin
    last_s = (idx_r == (len_r - ONE_C));
  end

  // Sampling window: decides whether z is counted at the coming edge, and
  // which bit position it belongs to.
  always_comb begin
    sample_en_s  = 1'b0;
    sample_pos_s = idx_r;
    case (state_r)
      S_SHIFT: begin
        if (MOORE != 0) begin
          // z in this cycle reflects the previous bit, so idx 0 shows nothing.
          sample_en_s  = (idx_r != {CNTW{1'b0}});
          sample_pos_s = idx_r - ONE_C;
        end else begin
          sample_en_s  = 1'b1;
          sample_pos_s = idx_r;
        end
      end
      S_DRAIN: begin
        if (MOORE != 0) begin
          // DRAIN carries the lagging response to the final bit.
          sample_en_s  = (len_r != {CNTW{1'b0}});
          sample_pos_s = len_r - ONE_C;
        end else begin
          sample_en_s  = 1'b0;
          sample_pos_s = idx_r;
        end
      end
      default: begin
        sample_en_s  = 1'b0;
        sample_pos_s = idx_r;
      end
    endcase
  end

  // Run FSM with registered detector drive, status and result outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      sr_r      <= {WIDTH{1'b0}};
      len_r     <= {CNTW{1'b0}};
      idx_r     <= {CNTW{1'b0}};
      x         <= 1'b0;
      det_clear <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_count <= {CNTW{1'b0}};
      first_hit <= ONES;
    end else if (abort && (state_r != S_IDLE)) begin
      // Cancel: results keep their partial values and no done pulse is issued.
      state_r   <= S_IDLE;
      x         <= 1'b0;
      det_clear <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (sample_en_s && z) begin
        hit_count <= sat_inc(hit_count);
        if (first_hit == ONES) begin
          first_hit <= sample_pos_s;
        end
      end
      case (state_r)
        S_IDLE: begin
          x    <= 1'b0;
          done <= 1'b0;
          // abort blocks a start that arrives in the same cycle.
          if (start && !abort) begin
            sr_r      <= pattern;
            len_r     <= len_clamp_s;
            idx_r     <= {CNTW{1'b0}};
            hit_count <= {CNTW{1'b0}};
            first_hit <= ONES;
            det_clear <= 1'b1;
            busy      <= 1'b1;
            state_r   <= S_CLEAR;
          end else begin
            det_clear <= 1'b0;
            busy      <= 1'b0;
          end
        end
        S_CLEAR: begin
          det_clear <= 1'b0;
          if (len_r != {CNTW{1'b0}}) begin
            x       <= sr_r[WIDTH-1];
            sr_r    <= {sr_r[WIDTH-2:0], 1'b0};
            state_r <= S_SHIFT;
          end else begin
            x       <= 1'b0;
            state_r <= S_DRAIN;
          end
        end
        S_SHIFT: begin
          if (last_s) begin
            x       <= 1'b0;
            state_r <= S_DRAIN;
          end else begin
            x     <= sr_r[WIDTH-1];
            sr_r  <= {sr_r[WIDTH-2:0], 1'b0};
            idx_r <= idx_r + ONE_C;
          end
        end
        S_DRAIN: begin
          x       <= 1'b0;
          done    <= 1'b1;
          state_r <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          x         <= 1'b0;
          det_clear <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Bench for seq_feed_ctrl: a Mealy instance and a Moore instance, each driving
// a behavioural overlapping "11" detector model. Table-driven runs plus
// hand-written abort and reset sequences.
module tb_seq_feed_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  len;
  logic [15:0] pattern;
  logic        inj;

  logic        z_a, x_a, dc_a, busy_a, done_a;
  logic [4:0]  hc_a, fh_a;
  logic        z_b, x_b, dc_b, busy_b, done_b;
  logic [4:0]  hc_b, fh_b;

  logic        prev_a;
  logic        prev_b, zr_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] p;
    logic [4:0]  l;
    int          hits;
    int          first;
    int          lat;
    bit          do_inj;
    int          poke;
  } vec_t;

  vec_t vecs[10];

  always #5 clock = ~clock;

  seq_feed_ctrl #(.WIDTH(16), .CNTW(5), .MOORE(0)) u_mealy (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .len(len),
    .pattern(pattern), .z(z_a), .x(x_a), .det_clear(dc_a), .busy(busy_a),
    .done(done_a), .hit_count(hc_a), .first_hit(fh_a)
  );

  seq_feed_ctrl #(.WIDTH(16), .CNTW(5), .MOORE(1)) u_moore (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .len(len),
    .pattern(pattern), .z(z_b), .x(x_b), .det_clear(dc_b), .busy(busy_b),
    .done(done_b), .hit_count(hc_b), .first_hit(fh_b)
  );

  // Mealy "11" detector model: z is combinational from x and the last bit.
  always @(posedge clock or negedge reset) begin
    if (!reset) prev_a <= 1'b0;
    else if (dc_a) prev_a <= 1'b0;
    else prev_a <= x_a;
  end
  assign z_a = x_a & prev_a;

  // Moore "11" detector model: registered z, one cycle behind x.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_b <= 1'b0;
      zr_b   <= 1'b0;
    end else if (dc_b) begin
      prev_b <= 1'b0;
      zr_b   <= 1'b0;
    end else begin
      zr_b   <= x_b & prev_b;
      prev_b <= x_b;
    end
  end
  assign z_b = zr_b | inj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One run on both instances; called at a negedge, returns at a negedge.
  task automatic run_case(input string nm, input logic [15:0] p, input logic [4:0] l,
                          input int exp_hits, input int exp_first, input int exp_lat,
                          input bit do_inj, input int poke_c);
    int   lat_a;
    int   lat_b;
    int   eff;
    bit   x_ok;
    logic bitv;
    eff = (l > 5'd16) ? 16 : int'(l);
    pattern = p;
    len     = l;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat_a = 0;
    lat_b = 0;
    x_ok  = 1'b1;
    for (int c = 1; c <= 40 && (lat_a == 0 || lat_b == 0); c++) begin
      @(negedge clock);
      if (c == 1) chk({nm, "_clear"}, {26'd0, dc_a, dc_b, busy_a, busy_b, x_a, x_b}, 32'b111100);
      if (c >= 2 && c <= eff + 1) begin
        bitv = p[15 - (c - 2)];
        if (x_a !== bitv || x_b !== bitv) x_ok = 1'b0;
      end
      if (c == eff + 2 && (x_a !== 1'b0 || x_b !== 1'b0)) x_ok = 1'b0;
      inj = do_inj && (c == 2);
      if (poke_c != 0 && c == poke_c) begin
        start   = 1'b1;
        pattern = 16'h0000;
        len     = 5'd1;
      end else begin
        start = 1'b0;
      end
      if (done_a && lat_a == 0) lat_a = c;
      if (done_b && lat_b == 0) lat_b = c;
    end
    start = 1'b0;
    inj   = 1'b0;
    chk({nm, "_lat_mealy"}, lat_a, exp_lat);
    chk({nm, "_lat_moore"}, lat_b, exp_lat);
    chk({nm, "_xseq"}, {31'd0, x_ok}, 32'd1);
    chk({nm, "_hits_mealy"}, hc_a, exp_hits);
    chk({nm, "_first_mealy"}, fh_a, exp_first);
    chk({nm, "_hits_moore"}, hc_b, exp_hits);
    chk({nm, "_first_moore"}, fh_b, exp_first);
    @(negedge clock);
    chk({nm, "_after"}, {16'd0, busy_a, busy_b, done_a, done_b, 2'b00, hc_a, fh_a},
        {16'd0, 4'b0000, 2'b00, 5'(exp_hits), 5'(exp_first)});
  endtask

  initial begin
    vecs[0] = '{16'hE732, 5'd15, 5,  1,  18, 1'b0, 0};
    vecs[1] = '{16'hE732, 5'd15, 5,  1,  18, 1'b1, 0};
    vecs[2] = '{16'h0000, 5'd16, 0,  31, 19, 1'b0, 0};
    vecs[3] = '{16'hFFFF, 5'd0,  0,  31, 3,  1'b0, 0};
    vecs[4] = '{16'hFFFF, 5'd20, 15, 1,  19, 1'b0, 0};
    vecs[5] = '{16'h0003, 5'd16, 1,  15, 19, 1'b0, 0};
    vecs[6] = '{16'hFFFF, 5'd1,  0,  31, 4,  1'b0, 0};
    vecs[7] = '{16'hC000, 5'd2,  1,  1,  5,  1'b0, 0};
    vecs[8] = '{16'hAAAA, 5'd16, 0,  31, 19, 1'b0, 0};
    vecs[9] = '{16'hE732, 5'd15, 5,  1,  18, 1'b0, 5};

    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    len     = 5'd0;
    pattern = 16'h0000;
    inj     = 1'b0;
    @(negedge clock);
    chk("reset_ctl", {28'd0, x_a, dc_a, busy_a, done_a}, 32'd0);
    chk("reset_res", {22'd0, hc_b, fh_b}, {22'd0, 5'd0, 5'h1F});
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Table-driven runs, issued back to back.
    for (int i = 0; i < 10; i++) begin
      run_case($sformatf("vec%0d", i), vecs[i].p, vecs[i].l, vecs[i].hits,
               vecs[i].first, vecs[i].lat, vecs[i].do_inj, vecs[i].poke);
    end

    // Abort in the 4th SHIFT cycle, with start asserted alongside.
    pattern = 16'hE732;
    len     = 5'd15;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clock);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk("abort_ctl", {26'd0, busy_a, busy_b, done_a, done_b, x_a, x_b}, 32'd0);
    chk("abort_partial", {22'd0, hc_a, fh_a}, {22'd0, 5'd2, 5'd1});
    chk("abort_first_moore", fh_b, 32'd1);
    run_case("after_abort", 16'hE732, 5'd15, 5, 1, 18, 1'b0, 0);

    // abort and start together while idle: start is dropped.
    abort = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk("idle_abort_start", {30'd0, busy_a, busy_b}, 32'd0);

    // Reset asserted mid-SHIFT.
    pattern = 16'hFFFF;
    len     = 5'd16;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 6; c++) @(negedge clock);
    chk("pre_reset_x", {31'd0, x_a}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrun_reset_ctl", {24'd0, x_a, dc_a, busy_a, done_a, x_b, dc_b, busy_b, done_b}, 32'd0);
    chk("midrun_reset_res", {12'd0, hc_a, fh_a, hc_b, fh_b},
        {12'd0, 5'd0, 5'h1F, 5'd0, 5'h1F});
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_case("after_reset", 16'hC000, 5'd2, 1, 1, 5, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
